// File: rtl/sub_pipe_pkg.sv
// Shared types and width helpers for the sub_pipe_acc subtract pipeline.
// Helpers work on a fixed 64-bit container; callers cast the result down to their width.
package sub_pipe_pkg;

  localparam int MAXW = 64;

  typedef logic [MAXW-1:0] wide_t;

  typedef enum logic [1:0] {
    OP_SUB  = 2'd0,
    OP_ACC  = 2'd1,
    OP_LOAD = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  // Extend the low `width` bits of value across the container, sign- or zero-filled.
  function automatic wide_t ext_w(input wide_t value, input int width, input logic sgn);
    wide_t r;
    logic  fill;
    fill = 1'b0;
    for (int i = 0; i < MAXW; i++)
      if (i == width - 1) fill = sgn & value[i];
    r = value;
    for (int i = 0; i < MAXW; i++)
      if (i >= width) r[i] = fill;
    return r;
  endfunction

  // d is a sign-extended exact difference; true when it is representable in wo bits.
  function automatic logic fits_w(input wide_t d, input int wo, input logic sgn);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAXW; i++) begin
      if (sgn && (i >= wo - 1) && (d[i] != d[MAXW-1])) ok = 1'b0;
      if (!sgn && (i >= wo) && d[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sub_pipe_core.sv
// Combinational second-stage datapath: exact W-bit difference, truncated result,
// unsigned borrow and representability flag.
module sub_pipe_core
  import sub_pipe_pkg::*;
#(
  parameter int W  = 17,
  parameter int WO = 16
) (
  input  logic [W-1:0]  min_i,
  input  logic [W-1:0]  sub_i,
  input  op_e           op_i,
  input  logic          sgn_i,
  output logic [WO-1:0] res_o,
  output logic          borrow_o,
  output logic          ovf_o
);

  logic [W-1:0] diff_w;

  assign diff_w = min_i - sub_i;

  // W is one bit wider than any operand, so diff_w read as signed is the exact difference.
  always_comb begin
    res_o    = diff_w[WO-1:0];
    borrow_o = (min_i < sub_i);
    ovf_o    = !fits_w(ext_w(wide_t'(diff_w), W, 1'b1), WO, sgn_i);
    if (op_i == OP_LOAD) begin
      res_o    = min_i[WO-1:0];
      borrow_o = 1'b0;
      ovf_o    = !fits_w(ext_w(wide_t'(min_i), W, 1'b1), WO, sgn_i);
    end
  end

endmodule

// File: rtl/sub_pipe_acc.sv
// Two-stage subtract/accumulate pipeline with valid/ready flow control and a global stall.
// Widths up to 63 bits are supported by the shared helper container.
module sub_pipe_acc
  import sub_pipe_pkg::*;
#(
  parameter int WA = 16,
  parameter int WB = 16,
  parameter int WO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] in_a,
  input  logic [WB-1:0] in_b,
  input  logic          in_signed,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WO-1:0] out_res,
  output logic          out_borrow,
  output logic          out_ovf
);

  localparam int WAB = (WA > WB) ? WA : WB;
  localparam int W   = ((WAB > WO) ? WAB : WO) + 1;

  logic          stall;
  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_a_q, s1_a_d;
  logic [W-1:0]  s1_b_q, s1_b_d;
  op_e           s1_op_q, s1_op_d;
  logic          s1_sgn_q, s1_sgn_d;
  logic          out_valid_q, out_valid_d;
  logic [WO-1:0] out_res_q, out_res_d;
  logic          out_borrow_q, out_borrow_d;
  logic          out_ovf_q, out_ovf_d;
  logic [WO-1:0] acc_q, acc_d;

  logic [W-1:0]  a_ext, b_ext, acc_ext, s2_min;
  logic [WO-1:0] core_res;
  logic          core_borrow, core_ovf;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall && !rst;

  assign a_ext   = W'(ext_w(wide_t'(in_a), WA, in_signed));
  assign b_ext   = W'(ext_w(wide_t'(in_b), WB, in_signed));
  // acc is read in S2, so a preceding ACC has already written it back.
  assign acc_ext = W'(ext_w(wide_t'(acc_q), WO, s1_sgn_q));
  assign s2_min  = (s1_op_q == OP_ACC) ? acc_ext : s1_a_q;

  sub_pipe_core #(
    .W  (W),
    .WO (WO)
  ) u_core (
    .min_i    (s2_min),
    .sub_i    (s1_b_q),
    .op_i     (s1_op_q),
    .sgn_i    (s1_sgn_q),
    .res_o    (core_res),
    .borrow_o (core_borrow),
    .ovf_o    (core_ovf)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_op_d      = s1_op_q;
    s1_sgn_d     = s1_sgn_q;
    out_valid_d  = out_valid_q;
    out_res_d    = out_res_q;
    out_borrow_d = out_borrow_q;
    out_ovf_d    = out_ovf_q;
    acc_d        = acc_q;
    if (!stall) begin
      s1_valid_d = in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_a_d   = a_ext;
        s1_b_d   = b_ext;
        s1_op_d  = op_e'(in_op);
        s1_sgn_d = in_signed;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_res_d    = core_res;
        out_borrow_d = core_borrow;
        out_ovf_d    = core_ovf;
        if ((s1_op_q == OP_ACC) || (s1_op_q == OP_LOAD)) acc_d = core_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= OP_SUB;
      s1_sgn_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_res_q    <= '0;
      out_borrow_q <= 1'b0;
      out_ovf_q    <= 1'b0;
      acc_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      s1_sgn_q     <= s1_sgn_d;
      out_valid_q  <= out_valid_d;
      out_res_q    <= out_res_d;
      out_borrow_q <= out_borrow_d;
      out_ovf_q    <= out_ovf_d;
      acc_q        <= acc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_res    = out_res_q;
  assign out_borrow = out_borrow_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_sub_pipe_acc.sv
// Bench for sub_pipe_acc: three width configurations checked against a value-level
// reference model (integer arithmetic on interpreted operands).
module tb_sub_pipe_acc;

  typedef struct {
    longint res;
    bit     borrow;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // x: WA=9 WB=6 WO=16
  logic        x_in_valid, x_in_ready, x_in_signed, x_out_valid, x_out_ready, x_out_borrow, x_out_ovf;
  logic [8:0]  x_in_a;
  logic [5:0]  x_in_b;
  logic [1:0]  x_in_op;
  logic [15:0] x_out_res;
  // y: WA=9 WB=9 WO=7
  logic        y_in_valid, y_in_ready, y_in_signed, y_out_valid, y_out_ready, y_out_borrow, y_out_ovf;
  logic [8:0]  y_in_a;
  logic [8:0]  y_in_b;
  logic [1:0]  y_in_op;
  logic [6:0]  y_out_res;
  // z: WA=12 WB=10 WO=8
  logic        z_in_valid, z_in_ready, z_in_signed, z_out_valid, z_out_ready, z_out_borrow, z_out_ovf;
  logic [11:0] z_in_a;
  logic [9:0]  z_in_b;
  logic [1:0]  z_in_op;
  logic [7:0]  z_out_res;

  sub_pipe_acc #(.WA(9), .WB(6), .WO(16)) u_x (
    .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready), .in_a(x_in_a),
    .in_b(x_in_b), .in_signed(x_in_signed), .in_op(x_in_op), .out_valid(x_out_valid),
    .out_ready(x_out_ready), .out_res(x_out_res), .out_borrow(x_out_borrow), .out_ovf(x_out_ovf)
  );
  sub_pipe_acc #(.WA(9), .WB(9), .WO(7)) u_y (
    .clk(clk), .rst(rst), .in_valid(y_in_valid), .in_ready(y_in_ready), .in_a(y_in_a),
    .in_b(y_in_b), .in_signed(y_in_signed), .in_op(y_in_op), .out_valid(y_out_valid),
    .out_ready(y_out_ready), .out_res(y_out_res), .out_borrow(y_out_borrow), .out_ovf(y_out_ovf)
  );
  sub_pipe_acc #(.WA(12), .WB(10), .WO(8)) u_z (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready), .in_a(z_in_a),
    .in_b(z_in_b), .in_signed(z_in_signed), .in_op(z_in_op), .out_valid(z_out_valid),
    .out_ready(z_out_ready), .out_res(z_out_res), .out_borrow(z_out_borrow), .out_ovf(z_out_ovf)
  );

  exp_t   zq[$];
  longint z_acc = 0;
  longint x_acc = 0;
  longint y_acc = 0;

  // Numeric value of the low w bits of x under the given signedness.
  function automatic longint interp(input longint x, input int w, input bit sgn);
    longint v;
    v = x & ((longint'(1) << w) - 1);
    if (sgn && (((v >> (w - 1)) & 1) != 0)) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic exp_t model(input int wa, input int wb, input int wo, input int op,
                                 input longint a, input longint b, input longint acc, input bit sgn);
    exp_t   e;
    int     w;
    longint minv, bv, d, lo, hi, mw;
    w    = ((wa > wb) ? ((wa > wo) ? wa : wo) : ((wb > wo) ? wb : wo)) + 1;
    mw   = (longint'(1) << w) - 1;
    minv = (op == 1) ? interp(acc, wo, sgn) : interp(a, wa, sgn);
    bv   = interp(b, wb, sgn);
    if (sgn) begin
      lo = -(longint'(1) << (wo - 1));
      hi = (longint'(1) << (wo - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << wo) - 1;
    end
    if (op == 2) begin
      d        = minv;
      e.borrow = 1'b0;
    end else begin
      d        = minv - bv;
      e.borrow = ((minv & mw) < (bv & mw));
    end
    e.res = d & ((longint'(1) << wo) - 1);
    e.ovf = (d < lo) || (d > hi);
    return e;
  endfunction

  task automatic x_one(input logic [8:0] a, input logic [5:0] b, input bit sgn, input logic [1:0] op,
                       output logic v1, output logic v2, output logic [15:0] r, output logic bo, output logic ov);
    @(negedge clk);
    x_in_valid = 1'b1; x_in_a = a; x_in_b = b; x_in_signed = sgn; x_in_op = op;
    @(negedge clk);
    x_in_valid = 1'b0;
    v1 = x_out_valid;
    @(negedge clk);
    v2 = x_out_valid; r = x_out_res; bo = x_out_borrow; ov = x_out_ovf;
  endtask

  task automatic y_one(input logic [8:0] a, input logic [8:0] b, input bit sgn, input logic [1:0] op,
                       output logic v1, output logic v2, output logic [6:0] r, output logic bo, output logic ov);
    @(negedge clk);
    y_in_valid = 1'b1; y_in_a = a; y_in_b = b; y_in_signed = sgn; y_in_op = op;
    @(negedge clk);
    y_in_valid = 1'b0;
    v1 = y_out_valid;
    @(negedge clk);
    v2 = y_out_valid; r = y_out_res; bo = y_out_borrow; ov = y_out_ovf;
  endtask

  // One z cycle: drive at negedge, then report what the next rising edge will commit.
  task automatic z_step(input bit v, input logic [11:0] a, input logic [9:0] b, input bit sgn,
                        input logic [1:0] op, input bit rdy, output bit acc_o, output bit fire_o);
    exp_t e;
    @(negedge clk);
    z_in_valid = v; z_in_a = a; z_in_b = b; z_in_signed = sgn; z_in_op = op; z_out_ready = rdy;
    #1;
    acc_o  = z_in_valid && z_in_ready;
    fire_o = z_out_valid && z_out_ready;
    if (acc_o) begin
      e = model(12, 10, 8, int'(op), longint'(a), longint'(b), z_acc, sgn);
      if (op == 2'd1 || op == 2'd2) z_acc = e.res;
      zq.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (z_in_ready !== 1'b0 || z_out_valid !== 1'b0 || x_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b/%b, required 0/0/0", z_in_ready, z_out_valid, x_out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (z_in_ready !== 1'b1 || y_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%b/%b, required 1/1", z_in_ready, y_in_ready);
    end
    vectors++;
    if (z_out_res !== 8'h00 || z_out_borrow !== 1'b0 || z_out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: res=%h borrow=%b ovf=%b, required 00 0 0", z_out_res, z_out_borrow, z_out_ovf);
    end
    $display("reset: checked");
  endtask

  task automatic test_sub_x();
    logic v1, v2, bo, ov;
    logic [15:0] r;
    logic [8:0] a;
    logic [5:0] b;
    logic [1:0] op;
    bit s;
    exp_t e;
    x_one(9'h000, 6'h01, 1'b0, 2'd0, v1, v2, r, bo, ov);
    vectors++;
    if (v1 !== 1'b0 || v2 !== 1'b1) begin
      miscompares++;
      $display("FAIL x_latency: valid after 1=%b after 2=%b, required 0 then 1", v1, v2);
    end
    vectors++;
    if (r !== 16'hFFFF || bo !== 1'b1 || ov !== 1'b1) begin
      miscompares++;
      $display("FAIL x_unsigned_sub: res=%h borrow=%b ovf=%b, required ffff 1 1", r, bo, ov);
    end
    $display("x unsigned 000-01: res=%h borrow=%b ovf=%b", r, bo, ov);
    x_one(9'h100, 6'h20, 1'b1, 2'd0, v1, v2, r, bo, ov);
    e = model(9, 6, 16, 0, 64'h100, 64'h20, x_acc, 1'b1);
    vectors++;
    if (r !== 16'hFF20 || ov !== 1'b0 || bo !== e.borrow) begin
      miscompares++;
      $display("FAIL x_signed_sub: res=%h borrow=%b ovf=%b, required ff20 %b 0", r, bo, ov, e.borrow);
    end
    $display("x signed 100-20: res=%h borrow=%b ovf=%b", r, bo, ov);
    for (int i = 0; i < 12; i++) begin
      a = 9'($urandom); b = 6'($urandom); s = 1'($urandom); op = 2'($urandom);
      x_one(a, b, s, op, v1, v2, r, bo, ov);
      e = model(9, 6, 16, int'(op), longint'(a), longint'(b), x_acc, s);
      if (op == 2'd1 || op == 2'd2) x_acc = e.res;
      vectors++;
      if (v2 !== 1'b1 || 64'(r) !== 64'(e.res) || bo !== e.borrow || ov !== e.ovf) begin
        miscompares++;
        $display("FAIL x_random: op=%0d s=%b a=%h b=%h got v=%b res=%h bo=%b ov=%b, required res=%h bo=%b ov=%b",
                 op, s, a, b, v2, r, bo, ov, 16'(e.res), e.borrow, e.ovf);
      end
      $display("x op=%0d s=%b a=%h b=%h: res=%h borrow=%b ovf=%b", op, s, a, b, r, bo, ov);
    end
  endtask

  task automatic test_ovf_y();
    logic v1, v2, bo, ov;
    logic [6:0] r;
    logic [8:0] ta [7] = '{9'h0FF, 9'h03F, 9'h040, 9'h07F, 9'h080, 9'h07F, 9'h1FF};
    logic [8:0] tb [7] = '{9'h1FF, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
    bit         ts [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0] to [7] = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd2, 2'd2};
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      y_one(ta[i], tb[i], ts[i], to[i], v1, v2, r, bo, ov);
      e = model(9, 9, 7, int'(to[i]), longint'(ta[i]), longint'(tb[i]), y_acc, ts[i]);
      if (to[i] == 2'd1 || to[i] == 2'd2) y_acc = e.res;
      vectors++;
      if (v2 !== 1'b1 || 64'(r) !== 64'(e.res) || bo !== e.borrow || ov !== e.ovf) begin
        miscompares++;
        $display("FAIL y_boundary%0d: v=%b res=%h bo=%b ov=%b, required res=%h bo=%b ov=%b",
                 i, v2, r, bo, ov, 7'(e.res), e.borrow, e.ovf);
      end
      if (i == 0) begin
        vectors++;
        if (r !== 7'h00 || ov !== 1'b1) begin
          miscompares++;
          $display("FAIL y_signed_wrap: res=%h ovf=%b, required 00 1", r, ov);
        end
      end
      $display("y op=%0d s=%b a=%h b=%h: res=%h borrow=%b ovf=%b", to[i], ts[i], ta[i], tb[i], r, bo, ov);
    end
  endtask

  task automatic test_acc_chain();
    logic [7:0] exp_res [4] = '{8'h05, 8'h02, 8'hFF, 8'hFC};
    bit         exp_bo  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit a_f, f;
    int k = 0;
    exp_t e;
    for (int c = 0; c < 12 && k < 4; c++) begin
      if (c < 4) begin
        z_step(1'b1, 12'd5, 10'd3, 1'b1, (c == 0) ? 2'd2 : 2'd1, 1'b1, a_f, f);
        vectors++;
        if (!a_f) begin
          miscompares++;
          $display("FAIL acc_chain_accept: cycle %0d accept=0, required 1", c);
        end
      end else begin
        z_step(1'b0, 12'd0, 10'd0, 1'b1, 2'd0, 1'b1, a_f, f);
      end
      if (f) begin
        if (zq.size() > 0) e = zq.pop_front();
        vectors++;
        if (z_out_res !== exp_res[k] || z_out_borrow !== exp_bo[k] || z_out_ovf !== 1'b0 || c != k + 2) begin
          miscompares++;
          $display("FAIL acc_chain%0d: cycle %0d res=%h bo=%b ov=%b, required cycle %0d res=%h bo=%b ov=0",
                   k, c, z_out_res, z_out_borrow, z_out_ovf, k + 2, exp_res[k], exp_bo[k]);
        end
        $display("acc chain %0d: res=%h borrow=%b ovf=%b", k, z_out_res, z_out_borrow, z_out_ovf);
        k++;
      end
    end
    vectors++;
    if (k != 4) begin
      miscompares++;
      $display("FAIL acc_chain_timeout: results seen=%0d, required 4", k);
    end
  endtask

  task automatic test_stall();
    logic [11:0] ra [3];
    logic [9:0]  rb [3];
    bit a_f, f, rdy, hold_v;
    logic [7:0] hold_res;
    logic hold_bo, hold_ov;
    int sent = 0, got = 0;
    exp_t e;
    hold_v = 1'b0; hold_res = '0; hold_bo = 1'b0; hold_ov = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra[i] = 12'($urandom); rb[i] = 10'($urandom);
    end
    for (int c = 0; c < 20 && got < 3; c++) begin
      rdy = (c >= 4);
      if (sent < 3) z_step(1'b1, ra[sent], rb[sent], 1'b1, 2'd0, rdy, a_f, f);
      else          z_step(1'b0, 12'd0, 10'd0, 1'b0, 2'd0, rdy, a_f, f);
      if (a_f) sent++;
      if (z_out_valid === 1'b1 && !rdy) begin
        vectors++;
        if (z_in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_in_ready: cycle %0d in_ready=%b, required 0", c, z_in_ready);
        end
        if (hold_v) begin
          vectors++;
          if (z_out_res !== hold_res || z_out_borrow !== hold_bo || z_out_ovf !== hold_ov) begin
            miscompares++;
            $display("FAIL stall_hold: res=%h bo=%b ov=%b, required %h %b %b",
                     z_out_res, z_out_borrow, z_out_ovf, hold_res, hold_bo, hold_ov);
          end
        end
        hold_v = 1'b1; hold_res = z_out_res; hold_bo = z_out_borrow; hold_ov = z_out_ovf;
      end
      if (f) begin
        vectors++;
        if (zq.size() == 0) begin
          miscompares++;
          $display("FAIL stall_extra_output: res=%h, required no output", z_out_res);
        end else begin
          e = zq.pop_front();
          if (64'(z_out_res) !== 64'(e.res) || z_out_borrow !== e.borrow || z_out_ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL stall_order%0d: res=%h bo=%b ov=%b, required %h %b %b",
                     got, z_out_res, z_out_borrow, z_out_ovf, 8'(e.res), e.borrow, e.ovf);
          end
        end
        $display("stall release %0d: res=%h borrow=%b ovf=%b", got, z_out_res, z_out_borrow, z_out_ovf);
        got++;
      end
    end
    vectors++;
    if (got != 3 || sent != 3 || zq.size() != 0) begin
      miscompares++;
      $display("FAIL stall_count: sent=%0d got=%0d pending=%0d, required 3 3 0", sent, got, zq.size());
    end
  endtask

  task automatic test_reset_stall();
    bit a_f, f;
    int got = 0;
    exp_t e;
    z_step(1'b1, 12'h012, 10'd0, 1'b0, 2'd2, 1'b0, a_f, f);
    z_step(1'b0, 12'd0, 10'd0, 1'b0, 2'd0, 1'b0, a_f, f);
    z_step(1'b0, 12'd0, 10'd0, 1'b0, 2'd0, 1'b0, a_f, f);
    vectors++;
    if (z_out_valid !== 1'b1 || z_out_res !== 8'h12) begin
      miscompares++;
      $display("FAIL rst_stall_setup: valid=%b res=%h, required 1 12", z_out_valid, z_out_res);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (z_in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stall_ready: in_ready=%b, required 0", z_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (z_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_stall_drop: out_valid=%b, required 0", z_out_valid);
    end
    zq.delete();
    z_acc = 0;
    z_step(1'b1, 12'($urandom), 10'd1, 1'b0, 2'd1, 1'b1, a_f, f);
    for (int c = 0; c < 6 && got == 0; c++) begin
      z_step(1'b0, 12'd0, 10'd0, 1'b0, 2'd0, 1'b1, a_f, f);
      if (f) begin
        got++;
        e = (zq.size() > 0) ? zq.pop_front() : '{res: 0, borrow: 1'b0, ovf: 1'b0};
        vectors++;
        if (z_out_res !== 8'hFF || z_out_borrow !== 1'b1 || z_out_ovf !== e.ovf) begin
          miscompares++;
          $display("FAIL rst_acc_cleared: res=%h bo=%b ov=%b, required ff 1 %b", z_out_res, z_out_borrow, z_out_ovf, e.ovf);
        end
        $display("post-reset ACC b=1: res=%h borrow=%b ovf=%b", z_out_res, z_out_borrow, z_out_ovf);
      end
    end
    vectors++;
    if (got != 1) begin
      miscompares++;
      $display("FAIL rst_acc_timeout: results seen=%0d, required 1", got);
    end
  endtask

  task automatic test_random();
    bit a_f, f, v, rdy, prev_stall;
    logic [7:0] p_res;
    logic p_bo, p_ov;
    int fires = 0;
    exp_t e;
    prev_stall = 1'b0; p_res = '0; p_bo = 1'b0; p_ov = 1'b0;
    for (int c = 0; c < 410; c++) begin
      v   = (c < 400) && ($urandom_range(0, 9) < 7);
      rdy = (c >= 400) || ($urandom_range(0, 9) < 7);
      z_step(v, 12'($urandom), 10'($urandom), 1'($urandom), 2'($urandom), rdy, a_f, f);
      if (prev_stall) begin
        vectors++;
        if (z_out_valid !== 1'b1 || z_out_res !== p_res || z_out_borrow !== p_bo || z_out_ovf !== p_ov) begin
          miscompares++;
          $display("FAIL rand_hold: cycle %0d v=%b res=%h bo=%b ov=%b, required 1 %h %b %b",
                   c, z_out_valid, z_out_res, z_out_borrow, z_out_ovf, p_res, p_bo, p_ov);
        end
      end
      prev_stall = (z_out_valid === 1'b1) && !rdy;
      p_res = z_out_res; p_bo = z_out_borrow; p_ov = z_out_ovf;
      if (f) begin
        vectors++;
        if (zq.size() == 0) begin
          miscompares++;
          $display("FAIL rand_extra_output: cycle %0d res=%h, required no output", c, z_out_res);
        end else begin
          e = zq.pop_front();
          if (64'(z_out_res) !== 64'(e.res) || z_out_borrow !== e.borrow || z_out_ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL rand_result: cycle %0d res=%h bo=%b ov=%b, required %h %b %b",
                     c, z_out_res, z_out_borrow, z_out_ovf, 8'(e.res), e.borrow, e.ovf);
          end
        end
        $display("rand #%0d: res=%h borrow=%b ovf=%b", fires, z_out_res, z_out_borrow, z_out_ovf);
        fires++;
      end
    end
    vectors++;
    if (zq.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: pending=%0d, required 0", zq.size());
    end
  endtask

  initial begin
    x_in_valid = 1'b0; x_in_a = '0; x_in_b = '0; x_in_signed = 1'b0; x_in_op = 2'd0; x_out_ready = 1'b1;
    y_in_valid = 1'b0; y_in_a = '0; y_in_b = '0; y_in_signed = 1'b0; y_in_op = 2'd0; y_out_ready = 1'b1;
    z_in_valid = 1'b0; z_in_a = '0; z_in_b = '0; z_in_signed = 1'b0; z_in_op = 2'd0; z_out_ready = 1'b1;
    test_reset();
    test_sub_x();
    test_ovf_y();
    test_acc_chain();
    test_stall();
    test_reset_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
